// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register-bus frame controller.
package spi_reg_pkg;

  localparam int K_DEF_DWIDTH = 16;
  localparam int K_CMD_RNW_BIT = K_DEF_DWIDTH - 1;
  localparam logic [K_DEF_DWIDTH-1:0] K_TMO_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_WAIT = 3'd2,
    WR_BUS  = 3'd3,
    RD_BUS  = 3'd4,
    RD_LOAD = 3'd5,
    RD_WAIT = 3'd6,
    ABORT   = 3'd7
  } state_t;

endpackage

// File: rtl/spi_reg_timeout.sv
// Bus access watchdog: counts cycles while i_run is high and pulses o_expired
// on the K_TIMEOUT-th cycle of the access.
module spi_reg_timeout #(
  parameter int K_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expired
);

  localparam int K_CW = $clog2(K_TIMEOUT + 1);

  logic [K_CW-1:0] r_cnt;

  assign o_expired = i_run && (r_cnt == K_CW'(K_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_expired) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + K_CW'(1);
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: decodes a command word, then runs auto-incrementing burst
// reads/writes on a req/ack register bus. Optional status word: SPI_REG_CTRL_STATUS_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int K_DWIDTH  = K_DEF_DWIDTH,
  parameter int K_AWIDTH  = 8,
  parameter int K_TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_spi_selected,
  input  logic [K_DWIDTH-1:0] i_spi_rx_data,
  input  logic                i_spi_rx_event,
  input  logic                i_spi_txe,
  output logic [K_DWIDTH-1:0] o_spi_tx_data,
  output logic                o_spi_tx_valid,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [K_AWIDTH-1:0] o_bus_addr,
  output logic [K_DWIDTH-1:0] o_bus_wdata,
  input  logic                i_bus_ack,
  input  logic [K_DWIDTH-1:0] i_bus_rdata,
  output logic                o_busy,
  output logic                o_err_timeout,
  output logic                o_err_overrun,
  input  logic                i_clr_err
);

  // The package constant describes the default width; other widths keep RnW in the MSB.
  localparam int K_RNW_BIT = (K_DWIDTH == K_DEF_DWIDTH) ? K_CMD_RNW_BIT : K_DWIDTH - 1;

  state_t              r_state;
  state_t              w_next;
  logic                r_sel_d;
  logic                r_sel_pend;
  logic                r_req;
  logic                r_rnw;
  logic                r_err_tmo;
  logic                r_err_ovr;
  logic [K_AWIDTH-1:0] r_addr;
  logic [K_DWIDTH-1:0] r_wdata;
  logic [K_DWIDTH-1:0] r_tx_data;

  logic                w_expired;
  logic                w_done;
  logic                w_sel_rise;
  logic                w_in_bus;
  logic                w_rx;
  logic                w_overrun;
  logic                w_tx_valid;
  logic [K_DWIDTH-1:0] w_tx_word;
  logic                w_unused;

  assign w_sel_rise = i_spi_selected && !r_sel_d;
  assign w_in_bus   = (r_state == WR_BUS) || (r_state == RD_BUS);
  assign w_done     = r_req && (i_bus_ack || w_expired);
  // A word coinciding with deselect is discarded, so rx only counts while selected.
  assign w_rx       = i_spi_rx_event && i_spi_selected;
  assign w_overrun  = w_rx && (w_in_bus || (r_state == RD_LOAD));
  assign w_unused   = ^{i_spi_txe, i_spi_rx_data};

  spi_reg_timeout #(
    .K_TIMEOUT (K_TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_run     (r_req),
    .i_clr     (w_done),
    .o_expired (w_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_sel_rise || (r_sel_pend && i_spi_selected)) w_next = CMD;
      CMD:     if (!i_spi_selected) w_next = IDLE;
               else if (w_rx) w_next = i_spi_rx_data[K_RNW_BIT] ? RD_BUS : WR_WAIT;
      WR_WAIT: if (!i_spi_selected) w_next = IDLE;
               else if (w_rx) w_next = WR_BUS;
      WR_BUS,
      RD_BUS:  if (!i_spi_selected) w_next = (r_req && !w_done) ? ABORT : IDLE;
               else if (w_done) w_next = (r_state == WR_BUS) ? WR_WAIT : RD_LOAD;
      RD_LOAD: w_next = i_spi_selected ? RD_WAIT : IDLE;
      RD_WAIT: if (!i_spi_selected) w_next = IDLE;
               else if (w_rx) w_next = RD_BUS;
      ABORT:   if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_sel_d    <= 1'b0;
      r_sel_pend <= 1'b0;
      r_req      <= 1'b0;
      r_rnw      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx_data  <= '0;
    end else begin
      r_state <= w_next;
      r_sel_d <= i_spi_selected;

      if (r_state == IDLE) r_sel_pend <= 1'b0;
      else if (r_state == ABORT && w_sel_rise) r_sel_pend <= 1'b1;

      if (w_done) r_req <= 1'b0;
      else if (w_in_bus && i_spi_selected) r_req <= 1'b1;

      if (r_state == CMD && w_rx) begin
        r_addr <= i_spi_rx_data[K_AWIDTH-1:0];
        r_rnw  <= i_spi_rx_data[K_RNW_BIT];
      end else if ((r_state == WR_BUS && w_done) || r_state == RD_LOAD) begin
        r_addr <= r_addr + K_AWIDTH'(1);
      end

      if (r_state == WR_WAIT && w_rx) r_wdata <= i_spi_rx_data;

      if (r_state == RD_BUS && w_done)
        r_tx_data <= i_bus_ack ? i_bus_rdata : K_DWIDTH'(K_TMO_WORD);
    end
  end

  // Sticky flags: a fresh error in the clear cycle takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_tmo <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      if (w_expired && !i_bus_ack) r_err_tmo <= 1'b1;
      else if (i_clr_err) r_err_tmo <= 1'b0;

      if (w_overrun) r_err_ovr <= 1'b1;
      else if (i_clr_err) r_err_ovr <= 1'b0;
    end
  end

`ifdef SPI_REG_CTRL_STATUS_EN
  logic [7:0] r_frame_cnt;
  logic       r_in_cmd_d;
  logic       w_status_load;

  assign w_status_load = (r_state == CMD) && !r_in_cmd_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_in_cmd_d  <= 1'b0;
    end else begin
      r_in_cmd_d <= (r_state == CMD);
      if (r_state != IDLE && w_next == IDLE) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_word  = r_tx_data;
    if (r_state == RD_LOAD) begin
      w_tx_valid = i_spi_selected;
    end else if (w_status_load) begin
      w_tx_valid                    = i_spi_selected;
      w_tx_word                     = '0;
      w_tx_word[K_DWIDTH-1 -: 8]    = r_frame_cnt;
      w_tx_word[1]                  = r_err_ovr;
      w_tx_word[0]                  = r_err_tmo;
    end
  end
`else
  always_comb begin
    w_tx_valid = (r_state == RD_LOAD) && i_spi_selected;
    w_tx_word  = r_tx_data;
  end
`endif

  assign o_spi_tx_valid = w_tx_valid;
  assign o_spi_tx_data  = w_tx_valid ? w_tx_word : '0;
  assign o_bus_req      = r_req;
  assign o_bus_we       = r_req && !r_rnw;
  assign o_bus_addr     = r_addr;
  assign o_bus_wdata    = r_wdata;
  assign o_busy         = (r_state != IDLE);
  assign o_err_timeout  = r_err_tmo;
  assign o_err_overrun  = r_err_ovr;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: the bench plays SPI slave and register bus.
// Define SPI_REG_CTRL_STATUS_EN for both RTL and bench to exercise the status word.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

`ifdef SPI_REG_CTRL_STATUS_EN
  localparam int K_ST = 1;
`else
  localparam int K_ST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_selected = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_event = 1'b0;
  logic        txe = 1'b1;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        busy;
  logic        err_tmo;
  logic        err_ovr;
  logic        clr_err = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_tx_junk = 0;
  int          n_req_rise = 0;
  logic        req_q = 1'b0;
  logic [15:0] tx_q[$];

  always #5 clk = ~clk;

  spi_reg_ctrl #(.K_DWIDTH(16), .K_AWIDTH(8), .K_TIMEOUT(64)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_spi_selected (spi_selected),
    .i_spi_rx_data  (rx_data),
    .i_spi_rx_event (rx_event),
    .i_spi_txe      (txe),
    .o_spi_tx_data  (tx_data),
    .o_spi_tx_valid (tx_valid),
    .o_bus_req      (bus_req),
    .o_bus_we       (bus_we),
    .o_bus_addr     (bus_addr),
    .o_bus_wdata    (bus_wdata),
    .i_bus_ack      (bus_ack),
    .i_bus_rdata    (bus_rdata),
    .o_busy         (busy),
    .o_err_timeout  (err_tmo),
    .o_err_overrun  (err_ovr),
    .i_clr_err      (clr_err)
  );

  // MISO capture and protocol watchers, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_valid) tx_q.push_back(tx_data);
    else if (tx_data != 16'h0) n_tx_junk++;
    if (tx_valid && !spi_selected) n_tx_junk++;
    if (bus_req && !req_q) n_req_rise++;
    req_q = bus_req;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    if (i < tx_q.size()) return {16'h0, tx_q[i]};
    return 32'hBAD0_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_begin();
    tx_q.delete();
    spi_selected = 1'b1;
    tick();
  endtask

  task automatic cs_end();
    spi_selected = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [15:0] d);
    rx_data  = d;
    rx_event = 1'b1;
    tick();
    rx_event = 1'b0;
    rx_data  = '0;
  endtask

  // Wait for a request, check its attributes, ack after `lat` cycles.
  task automatic bus_xfer(input string tag, input logic [7:0] addr, input logic we,
                          input logic [15:0] wdata, input int lat, input logic [15:0] rdata);
    int n = 0;
    while (!bus_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, " req"}, bus_req, 1);
    check({tag, " addr"}, bus_addr, addr);
    check({tag, " we"}, bus_we, we);
    if (we) check({tag, " wdata"}, bus_wdata, wdata);
    repeat (lat - 1) tick();
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check({tag, " req drop"}, bus_req, 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    int n;
    int rises;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst req", bus_req, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst addr", bus_addr, 0);
    check("rst errs", {err_tmo, err_ovr}, 0);
    rst_n = 1'b1;
    tick();

    // 1: write burst
    cs_begin();
    check("t1 busy", busy, 1);
    send_word(16'h0010);
    send_word(16'hAAAA);
    bus_xfer("t1 w0", 8'h10, 1'b1, 16'hAAAA, 2, 16'h0);
    send_word(16'h5555);
    bus_xfer("t1 w1", 8'h11, 1'b1, 16'h5555, 2, 16'h0);
    cs_end();
    check("t1 idle", busy, 0);
    check("t1 no tx", tx_q.size(), K_ST);

    // 2: read burst; the last dummy word's read is cut by deselect before req rises
    cs_begin();
    send_word(16'h8020);
    bus_xfer("t2 r0", 8'h20, 1'b0, 16'h0, 2, 16'h1234);
    tick();
    send_word(16'hFFFF);
    bus_xfer("t2 r1", 8'h21, 1'b0, 16'h0, 2, 16'h5678);
    tick();
    send_word(16'hFFFF);
    bus_xfer("t2 r2", 8'h22, 1'b0, 16'h0, 2, 16'h9ABC);
    tick();
    send_word(16'hFFFF);
    cs_end();
    check("t2 idle", busy, 0);
    check("t2 no req", bus_req, 0);
    check("t2 tx count", tx_q.size(), 3 + K_ST);
    check("t2 miso2", tx_at(K_ST), 16'h1234);
    check("t2 miso3", tx_at(K_ST + 1), 16'h5678);
    check("t2 miso4", tx_at(K_ST + 2), 16'h9ABC);

    // 3: timeout
    cs_begin();
    send_word(16'h8005);
    tick();
    check("t3 req", bus_req, 1);
    check("t3 addr", bus_addr, 8'h05);
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      tick();
    end
    check("t3 req cycles", n, 64);
    check("t3 err_tmo", err_tmo, 1);
    check("t3 tx_valid", tx_valid, 1);
    check("t3 tx_data", tx_data, 16'hDEAD);
    tick();
    send_word(16'h0000);
    cs_end();
    check("t3 miso", tx_at(K_ST), 16'hDEAD);
    pulse_clr();
    check("t3 clr", err_tmo, 0);

    // 4: address wrap, overrun, clear vs. new error
    cs_begin();
    send_word(16'h00FF);
    send_word(16'h1111);
    bus_xfer("t4 w0", 8'hFF, 1'b1, 16'h1111, 1, 16'h0);
    check("t4 wrap", bus_addr, 8'h00);
    send_word(16'h2222);
    send_word(16'h3333);
    check("t4 ovr", err_ovr, 1);
    bus_xfer("t4 w1", 8'h00, 1'b1, 16'h2222, 1, 16'h0);
    send_word(16'h4444);
    clr_err = 1'b1;
    send_word(16'h5555);
    clr_err = 1'b0;
    check("t4 ovr beats clr", err_ovr, 1);
    bus_xfer("t4 w2", 8'h01, 1'b1, 16'h4444, 1, 16'h0);
    cs_end();
    pulse_clr();
    check("t4 clr", err_ovr, 0);

    // 5: abort with a pending read, select re-raised during ABORT
    cs_begin();
    send_word(16'h8040);
    tick();
    check("t5 req", bus_req, 1);
    spi_selected = 1'b0;
    tick();
    check("t5 abort busy", busy, 1);
    check("t5 abort req", bus_req, 1);
    tick();
    spi_selected = 1'b1;
    repeat (3) tick();
    check("t5 req held", bus_req, 1);
    bus_ack   = 1'b1;
    bus_rdata = 16'hBEEF;
    tick();
    bus_ack   = 1'b0;
    check("t5 idle", busy, 0);
    check("t5 req drop", bus_req, 0);
    tick();
    check("t5 pending cmd", busy, 1);
    send_word(16'h0030);
    send_word(16'h6666);
    bus_xfer("t5 w0", 8'h30, 1'b1, 16'h6666, 2, 16'h0);
    cs_end();
    check("t5 no data tx", tx_q.size(), 2 * K_ST);
    check("t5 no err", {err_tmo, err_ovr}, 0);

    // Late ack while idle is ignored
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("late ack busy", busy, 0);
    check("late ack req", bus_req, 0);

    // Command-only write frame performs no bus access
    rises = n_req_rise;
    cs_begin();
    send_word(16'h0050);
    tick();
    cs_end();
    check("cmd-only no req", n_req_rise, rises);
    check("cmd-only no tx", tx_q.size(), K_ST);

`ifdef SPI_REG_CTRL_STATUS_EN
    // 6: status word after reset; second frame reports frame_cnt=1 and timeout
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cs_begin();
    send_word(16'h8006);
    tick();
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      tick();
    end
    tick();
    cs_end();
    check("t6 status1", tx_at(0), 16'h0000);
    check("t6 miso tmo", tx_at(1), 16'hDEAD);
    cs_begin();
    tick();
    cs_end();
    check("t6 status2", tx_at(0), 16'h0101);
`endif

    check("tx data zero when idle", n_tx_junk, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
